// File: rtl/imem_ecc_sink.sv
// Instruction memory sink: loader writes are stored as Hamming SEC-DED codewords,
// fetches are decoded combinationally, and corrected words are scrubbed back while running.
module imem_ecc_sink #(
  parameter int          DEPTH    = 64,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_we,
  input  logic [31:0] imem_waddr,
  input  logic [31:0] imem_wdata,
  input  logic        loader_done_in,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_data,
  output logic        ready,
  output logic        s_err,
  output logic        d_err,
  output logic        wr_viol,
  output logic [7:0]  serr_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;

  // Codeword layout: bit 0 is overall parity, check bits sit at positions 1,2,4,8,16,32,
  // data bits fill the remaining positions 3..38 in ascending order.
  function automatic logic [38:0] ecc_encode(input logic [31:0] data);
    logic [38:0] cw;
    logic        par;
    int          j;
    cw = '0;
    j  = 0;
    for (int p = 1; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[6'(p)] = data[5'(j)];
        j++;
      end
    end
    for (int k = 0; k < 6; k++) begin
      par = 1'b0;
      for (int p = 1; p < 39; p++) begin
        if (((p >> k) & 1) != 0) par = par ^ cw[6'(p)];
      end
      cw[6'(1 << k)] = par;
    end
    cw[0] = ^cw[38:1];
    return cw;
  endfunction

  function automatic logic [5:0] ecc_syndrome(input logic [38:0] cw);
    logic [5:0] syn;
    syn = '0;
    for (int k = 0; k < 6; k++) begin
      for (int p = 1; p < 39; p++) begin
        if (((p >> k) & 1) != 0) syn[3'(k)] = syn[3'(k)] ^ cw[6'(p)];
      end
    end
    return syn;
  endfunction

  function automatic logic [31:0] ecc_extract(input logic [38:0] cw);
    logic [31:0] data;
    int          j;
    data = '0;
    j    = 0;
    for (int p = 1; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        data[5'(j)] = cw[6'(p)];
        j++;
      end
    end
    return data;
  endfunction

  logic [38:0]    mem [0:DEPTH-1];
  state_t         r_state;
  logic           r_ready;
  logic           r_wr_viol;
  logic [7:0]     r_serr_cnt;
  logic [DEPTH-1:0] r_valid;

  logic [AW-1:0]  w_widx;
  logic [AW-1:0]  w_ridx;
  logic           w_w_oor;
  logic           w_r_oor;
  logic           w_wr_acc;
  logic           w_scrub;
  logic [38:0]    w_cw;
  logic [38:0]    w_fix;
  logic [5:0]     w_syn;
  logic           w_par_bad;
  logic [31:0]    w_rdata;
  logic           w_s_err;
  logic           w_d_err;
  logic           w_unused_lo;

  assign w_widx      = imem_waddr[AW+1:2];
  assign w_ridx      = rd_addr[AW+1:2];
  assign w_w_oor     = |imem_waddr[31:AW+2];
  assign w_r_oor     = |rd_addr[31:AW+2];
  assign w_unused_lo = ^rd_addr[1:0];
  // A write in the cycle rst is sampled low must never touch the array.
  assign w_wr_acc    = rst && imem_we && (r_state != RUN) &&
                       (imem_waddr[1:0] == 2'b00) && !w_w_oor;
  assign w_scrub     = (r_state == RUN) && w_s_err;

  // Fetch-side decode and correction
  always_comb begin
    w_cw      = mem[w_ridx];
    w_syn     = ecc_syndrome(w_cw);
    w_par_bad = ^w_cw;
    w_fix     = w_cw ^ (39'd1 << w_syn);
    w_rdata   = NOP_WORD;
    w_s_err   = 1'b0;
    w_d_err   = 1'b0;
    if (w_r_oor || !r_valid[w_ridx]) begin
      w_rdata = NOP_WORD;
    end else if (!w_par_bad) begin
      if (w_syn == 6'd0) begin
        w_rdata = ecc_extract(w_cw);
      end else begin
        w_d_err = 1'b1;
      end
    end else if (w_syn <= 6'd38) begin
      w_rdata = ecc_extract(w_fix);
      w_s_err = 1'b1;
    end else begin
      // Syndrome points past the codeword: cannot be a single flip.
      w_d_err = 1'b1;
    end
  end

  // Codeword storage: loader writes and run-time scrub write-back
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      mem[w_widx] <= ecc_encode(imem_wdata);
    end else if (w_scrub) begin
      mem[w_ridx] <= ecc_encode(w_rdata);
    end
  end

  // Load/run control, valid bits, violation flag and error counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_ready    <= 1'b0;
      r_wr_viol  <= 1'b0;
      r_serr_cnt <= 8'd0;
      r_valid    <= '0;
    end else begin
      if (w_wr_acc) r_valid[w_widx] <= 1'b1;
      if (imem_we && !w_wr_acc) r_wr_viol <= 1'b1;
      if (w_scrub && (r_serr_cnt != 8'hFF)) r_serr_cnt <= r_serr_cnt + 8'd1;
      case (r_state)
        IDLE: begin
          if (loader_done_in) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end else if (w_wr_acc) begin
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (loader_done_in) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end
        end
        RUN: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data  = w_rdata;
  assign s_err    = w_s_err;
  assign d_err    = w_d_err;
  assign ready    = r_ready;
  assign wr_viol  = r_wr_viol;
  assign serr_cnt = r_serr_cnt;

endmodule

// File: tb/tb_imem_ecc_sink.sv
// Directed bench for imem_ecc_sink: load, table-driven reads, error injection,
// scrubbing, dropped writes, mid-load reset and counter saturation.
module tb_imem_ecc_sink;
  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_we = 1'b0;
  logic [31:0] imem_waddr = 32'd0;
  logic [31:0] imem_wdata = 32'd0;
  logic        loader_done_in = 1'b0;
  logic [31:0] rd_addr = 32'd0;
  logic [31:0] rd_data;
  logic        ready;
  logic        s_err;
  logic        d_err;
  logic        wr_viol;
  logic [7:0]  serr_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        s;
    logic        d;
  } rd_vec_t;

  rd_vec_t     vecs[8];
  logic [31:0] w[4];
  logic [31:0] v[4];

  imem_ecc_sink #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .loader_done_in(loader_done_in), .rd_addr(rd_addr),
    .rd_data(rd_data), .ready(ready), .s_err(s_err), .d_err(d_err),
    .wr_viol(wr_viol), .serr_cnt(serr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    imem_we    = 1'b1;
    imem_waddr = a;
    imem_wdata = d;
    tick();
    imem_we    = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] d,
                        input logic s, input logic e);
    rd_addr = a;
    #1;
    chk({name, ".data"}, rd_data, d);
    chk({name, ".s_err"}, {31'd0, s_err}, {31'd0, s});
    chk({name, ".d_err"}, {31'd0, d_err}, {31'd0, e});
  endtask

  initial begin
    w[0] = 32'h00500093; w[1] = 32'h00A00113; w[2] = 32'h002081B3; w[3] = 32'hDEADBEEF;
    v[0] = 32'h12345678; v[1] = 32'h9ABCDEF0; v[2] = 32'h0F0F0F0F; v[3] = 32'hFFFFFFFF;
    vecs[0] = '{32'd8,          w[2], 1'b0, 1'b0};
    vecs[1] = '{32'd0,          w[0], 1'b0, 1'b0};
    vecs[2] = '{32'd4,          w[1], 1'b0, 1'b0};
    vecs[3] = '{32'd12,         w[3], 1'b0, 1'b0};
    vecs[4] = '{32'd11,         w[2], 1'b0, 1'b0};
    vecs[5] = '{32'd16,         NOP,  1'b0, 1'b0};
    vecs[6] = '{32'd256,        NOP,  1'b0, 1'b0};
    vecs[7] = '{32'hFFFFFFFC,   NOP,  1'b0, 1'b0};

    // Reset with a write held high: nothing may be stored
    imem_we = 1'b1; imem_waddr = 32'd0; imem_wdata = 32'hFFFFFFFF;
    tick(); tick();
    imem_we = 1'b0;
    #1;
    chk("rst.ready", {31'd0, ready}, 32'd0);
    chk("rst.wr_viol", {31'd0, wr_viol}, 32'd0);
    chk("rst.serr_cnt", {24'd0, serr_cnt}, 32'd0);
    rd_chk("rst.rd0", 32'd0, NOP, 1'b0, 1'b0);
    rst = 1'b1;
    tick();

    // Out-of-range write must be dropped, not alias onto word 0
    wr(DEPTH * 4, 32'h55555555);
    chk("oor.wr_viol", {31'd0, wr_viol}, 32'd1);
    rd_chk("oor.rd0", 32'd0, NOP, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk("oor.viol_clr", {31'd0, wr_viol}, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Normal load
    for (int i = 0; i < 4; i++) wr(32'(i * 4), w[i]);
    chk("load.wr_viol", {31'd0, wr_viol}, 32'd0);
    chk("load.ready", {31'd0, ready}, 32'd0);
    wr(32'd6, 32'hBAD0BAD0);
    chk("misalign.wr_viol", {31'd0, wr_viol}, 32'd1);
    rd_chk("misalign.rd4", 32'd4, w[1], 1'b0, 1'b0);

    // Error outside RUN is reported but neither scrubbed nor counted
    dut.mem[3][10] = ~dut.mem[3][10];
    rd_chk("load_err.a", 32'd12, w[3], 1'b1, 1'b0);
    tick();
    chk("load_err.cnt", {24'd0, serr_cnt}, 32'd0);
    rd_chk("load_err.b", 32'd12, w[3], 1'b1, 1'b0);
    dut.mem[3][10] = ~dut.mem[3][10];

    loader_done_in = 1'b1;
    tick();
    chk("run.ready", {31'd0, ready}, 32'd1);

    for (int i = 0; i < 8; i++) rd_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data,
                                       vecs[i].s, vecs[i].d);

    // Write after ready is dropped
    wr(32'd0, 32'hCAFEF00D);
    rd_chk("runwr.rd0", 32'd0, w[0], 1'b0, 1'b0);

    // Single data-bit error corrected and scrubbed
    dut.mem[1][7] = ~dut.mem[1][7];
    rd_chk("sec.a", 32'd4, w[1], 1'b1, 1'b0);
    tick();
    chk("sec.cnt", {24'd0, serr_cnt}, 32'd1);
    rd_chk("sec.b", 32'd4, w[1], 1'b0, 1'b0);

    // Overall parity bit alone
    dut.mem[3][0] = ~dut.mem[3][0];
    rd_chk("par.a", 32'd12, w[3], 1'b1, 1'b0);
    tick();
    chk("par.cnt", {24'd0, serr_cnt}, 32'd2);
    rd_chk("par.b", 32'd12, w[3], 1'b0, 1'b0);

    // A check bit alone
    dut.mem[2][4] = ~dut.mem[2][4];
    rd_chk("chkbit.a", 32'd8, w[2], 1'b1, 1'b0);
    tick();
    chk("chkbit.cnt", {24'd0, serr_cnt}, 32'd3);
    rd_chk("chkbit.b", 32'd8, w[2], 1'b0, 1'b0);

    // Double error: NOP, never written back
    dut.mem[2][3]  = ~dut.mem[2][3];
    dut.mem[2][20] = ~dut.mem[2][20];
    rd_chk("ded.a", 32'd8, NOP, 1'b0, 1'b1);
    tick();
    chk("ded.cnt", {24'd0, serr_cnt}, 32'd3);
    rd_chk("ded.b", 32'd8, NOP, 1'b0, 1'b1);
    dut.mem[2][3]  = ~dut.mem[2][3];
    dut.mem[2][20] = ~dut.mem[2][20];
    rd_chk("ded.restored", 32'd8, w[2], 1'b0, 1'b0);
    chk("run.wr_viol", {31'd0, wr_viol}, 32'd1);

    // Asynchronous reset out of RUN
    rst = 1'b0;
    loader_done_in = 1'b0;
    #1;
    chk("arst.ready", {31'd0, ready}, 32'd0);
    chk("arst.cnt", {24'd0, serr_cnt}, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Reset in the middle of a load
    wr(32'd0, v[0]);
    wr(32'd4, v[1]);
    rst = 1'b0;
    #1;
    chk("midload.ready", {31'd0, ready}, 32'd0);
    rd_chk("midload.rd0", 32'd0, NOP, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();

    // Full reload, last write coinciding with loader_done_in
    for (int i = 0; i < 3; i++) wr(32'(i * 4), v[i]);
    loader_done_in = 1'b1;
    wr(32'd12, v[3]);
    chk("reload.ready", {31'd0, ready}, 32'd1);
    chk("reload.wr_viol", {31'd0, wr_viol}, 32'd0);
    for (int i = 0; i < 4; i++) rd_chk($sformatf("reload%0d", i), 32'(i * 4), v[i], 1'b0, 1'b0);

    // Counter saturation
    rd_addr = 32'd0;
    for (int i = 1; i <= 300; i++) begin
      dut.mem[0][5] = ~dut.mem[0][5];
      tick();
      if (i == 254) chk("sat.254", {24'd0, serr_cnt}, 32'd254);
    end
    chk("sat.255", {24'd0, serr_cnt}, 32'd255);
    rd_chk("sat.rd0", 32'd0, v[0], 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_ecc_sink.md
IMEM_ECC_SINK -- requirements
Module: imem_ecc_sink

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning instruction words stored (power of two, 4..1024).
REQ-002 SHALL have parameter NOP_WORD, default 32'h00000013, meaning the value returned for never-written words.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; the ports are named clk and rst.
REQ-004 SHALL have ports: clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 imem_we  in  1  loader write strobe, one word per high cycle.
REQ-007 imem_waddr  in  32  loader byte address.
REQ-008 imem_wdata  in  32  loader instruction word.
REQ-009 loader_done_in  in  1  loader finished; level, stays high.
REQ-010 rd_addr  in  32  fetch byte address (PCF).
REQ-011 rd_data  out  32  corrected instruction.
REQ-012 ready  out  1  program locked, pipeline may run.
REQ-013 s_err  out  1  single-bit error corrected on the current read.
REQ-014 d_err  out  1  uncorrectable double-bit error on the current read.
REQ-015 wr_viol  out  1  sticky flag: a write was dropped.
REQ-016 serr_cnt  out  8  saturating count of corrected reads.

Function
REQ-017 The storage array SHALL be named mem, DEPTH x 39 bits, holding a Hamming SEC-DED codeword: 32 data bits, 6 check bits and 1 overall parity bit.
REQ-018 The FSM SHALL have three states, IDLE, LOAD and RUN, with reset state IDLE.
REQ-019 The FSM SHALL move IDLE->LOAD on the first accepted write.
REQ-020 The FSM SHALL move IDLE or LOAD ->RUN on the first cycle loader_done_in=1; there SHALL be no exit from RUN except reset.
REQ-021 A write SHALL be accepted only when imem_we=1, state!=RUN, imem_waddr[1:0]=0 and word index imem_waddr>>2 < DEPTH.
REQ-022 An accepted write SHALL be encoded and stored at the next clock edge, and SHALL set that word's valid bit.
REQ-023 Any write that is not accepted SHALL be dropped and SHALL set wr_viol at the next edge; wr_viol is sticky until reset.
REQ-024 If imem_we and loader_done_in rise in the same cycle, the write SHALL be accepted and the state SHALL become RUN.
REQ-025 ready SHALL be registered and equal 1 exactly while state=RUN.
REQ-026 The read path SHALL be combinational, with index rd_addr[log2(DEPTH)+1:2]; rd_addr[1:0] SHALL be ignored.
REQ-027 A read where rd_addr>>2 >= DEPTH, or of an invalid word, SHALL return NOP_WORD with s_err=d_err=0.
REQ-028 Decode: syndrome=0 and parity OK SHALL give clean data.
REQ-029 Decode: syndrome!=0 with parity bad SHALL give a single error; the data bit is flipped, s_err=1.
REQ-030 Decode: a bad overall parity bit alone SHALL give a single error in the parity bit only; data unchanged, s_err=1.
REQ-031 Decode: syndrome!=0 with parity OK SHALL give a double error; rd_data=NOP_WORD, d_err=1.
REQ-032 Scrub: in RUN, a read with s_err=1 SHALL write the re-encoded corrected codeword back to the same entry at the next edge, so the following read of it is clean.
REQ-033 Scrub: a double error SHALL never be written back.
REQ-034 serr_cnt SHALL increment once per clock cycle with s_err=1 while in RUN, and SHALL saturate at 255.
REQ-035 Outside RUN, rd_data and the error outputs SHALL still be driven, but scrubbing and counting SHALL be disabled.

Reset
REQ-036 rst=0 SHALL asynchronously force state=IDLE, ready=0, wr_viol=0, serr_cnt=0 and all valid bits=0.
REQ-037 Reset SHALL not clear mem contents; after reset, reads return NOP_WORD until words are rewritten.
REQ-038 Reset asserted mid-load SHALL abort the load; a fresh load SHALL be required.
REQ-039 Release of rst SHALL take effect on the next rising clk edge; no write is accepted in the release cycle if rst was low at that edge.

Verification
REQ-040 Load 4 words at addresses 0, 4, 8, 12, then loader_done_in=1 -> ready=1 on the next cycle; rd_addr=8 returns word 2; s_err=d_err=0.
REQ-041 In RUN, flip mem[1][7] hierarchically, then read addr 4 -> original word, s_err=1, serr_cnt=1; the next read of addr 4 gives s_err=0 (scrubbed).
REQ-042 Flip mem[2][3] and mem[2][20], then read addr 8 -> rd_data=32'h00000013, d_err=1; the entry is unchanged afterwards.
REQ-043 Write to addr 6, to addr DEPTH*4, and to addr 0 after ready=1 -> all three dropped, wr_viol=1, and contents at addr 0 unchanged.
REQ-044 Pull rst low after 2 of 4 writes -> ready=0, reads of addr 0 return 32'h00000013; a full reload then works.
REQ-045 Apply 300 corrected reads in RUN -> serr_cnt holds 255.
